// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg: shared types and helpers for the AHB slave-port arbiter
package ahb_arb_pkg;
  typedef enum logic {IDLE, OWNED} arb_state_e;
  localparam int DEF_REQ_NUM = 8;
  localparam int DEF_PRIOR_BIT = 2;
  typedef logic [DEF_REQ_NUM-1:0][DEF_PRIOR_BIT-1:0] prior_arr_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ahb_rr_pick.sv
// ahb_rr_pick: one-hot find-first over mask starting at ptr, wrapping
module ahb_rr_pick import ahb_arb_pkg::*; #(
  parameter int N = 8,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic         found
);
  logic [N-1:0] hi_mask, sel;
  always_comb begin
    hi_mask = mask & ({N{1'b1}} << ptr);
    sel = |hi_mask ? hi_mask : mask;
    onehot = sel & -sel;
    found = |mask;
  end
endmodule

// File: rtl/ahb_slave_arbiter.sv
// ahb_slave_arbiter: priority + round-robin burst-locked arbiter for one AHB slave port
// Define AHB_ARB_TIMEOUT_EN to force release of a grant held MAX_HOLD cycles.
module ahb_slave_arbiter import ahb_arb_pkg::*; #(
  parameter int REQ_NUM = 8,
  parameter int PRIOR_BIT = 2,
  parameter int PRIOR_LEVEL = 4,
  parameter int MAX_HOLD = 64
) (
  input  logic                              hclk,
  input  logic                              hreset_n,
  input  logic [REQ_NUM-1:0]                hreq,
  input  logic [REQ_NUM-1:0][PRIOR_BIT-1:0] hprior,
  input  logic [REQ_NUM-1:0]                hlast,
  input  logic                              hready,
  output logic [REQ_NUM-1:0]                hgrant,
  output logic [idx_w(REQ_NUM)-1:0]         hmaster,
  output logic                              hmaster_valid,
  output logic                              arb_timeout
);
  localparam int W = idx_w(REQ_NUM);
  if (REQ_NUM < 2 || REQ_NUM > 16 || PRIOR_LEVEL != 2**PRIOR_BIT || MAX_HOLD < 2) begin : g_bad_cfg
    $error("ahb_slave_arbiter: illegal parameter set");
  end
  arb_state_e state;
  logic [W-1:0] rr_ptr, next_ptr, pick_ptr;
  logic [REQ_NUM-1:0] req_eff, cand, win_oh;
  logic [PRIOR_BIT-1:0] top_lvl;
  logic found, norm_rel, rel, to;
  assign norm_rel = state == OWNED && ((|(hgrant & hlast) && hready) || !(|(hgrant & hreq)));
  assign rel = norm_rel || to;
  assign next_ptr = hmaster == W'(REQ_NUM-1) ? '0 : hmaster + 1'b1;
  assign pick_ptr = rel ? next_ptr : rr_ptr;
  // the outgoing owner sits out the handover cycle only
  assign req_eff = hreq & ~(rel ? hgrant : '0);
  always_comb begin
    top_lvl = '0;
    for (int i = 0; i < REQ_NUM; i++)
      if (req_eff[i] && hprior[i] > top_lvl) top_lvl = hprior[i];
    cand = '0;
    for (int i = 0; i < REQ_NUM; i++)
      cand[i] = req_eff[i] && hprior[i] == top_lvl;
  end
  ahb_rr_pick #(.N(REQ_NUM)) u_pick (
    .mask   (cand),
    .ptr    (pick_ptr),
    .onehot (win_oh),
    .found  (found)
  );
  always_comb begin
    hmaster = '0;
    for (int i = 0; i < REQ_NUM; i++)
      if (hgrant[i]) hmaster = W'(i);
  end
  assign hmaster_valid = |hgrant;
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state <= IDLE;
      hgrant <= '0;
      rr_ptr <= '0;
    end else begin
      if (state == IDLE || rel) begin
        hgrant <= win_oh;
        state <= found ? OWNED : IDLE;
      end
      if (rel) rr_ptr <= next_ptr;
    end
  end
`ifdef AHB_ARB_TIMEOUT_EN
  localparam int HW = idx_w(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD-1);
  logic [HW-1:0] hold_cnt;
  assign to = state == OWNED && !norm_rel && hold_cnt == HOLD_LAST;
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      hold_cnt <= '0;
      arb_timeout <= 1'b0;
    end else begin
      hold_cnt <= (state == IDLE || rel) ? '0 : (hold_cnt != HOLD_LAST ? hold_cnt + 1'b1 : hold_cnt);
      arb_timeout <= to;
    end
  end
`else
  assign to = 1'b0;
  assign arb_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// tb_ahb_slave_arbiter: directed self-checking bench for ahb_slave_arbiter
module tb_ahb_slave_arbiter;
  import ahb_arb_pkg::*;
  logic hclk = 1'b0;
  logic hreset_n;
  logic [7:0] hreq, hlast, hgrant;
  prior_arr_t hp;
  logic hready, hmaster_valid, arb_timeout;
  logic [2:0] hmaster;
  int checks = 0;
  int errors = 0;
  always #5 hclk = ~hclk;
  ahb_slave_arbiter #(.REQ_NUM(8), .PRIOR_BIT(2), .PRIOR_LEVEL(4), .MAX_HOLD(4)) dut (
    .hclk          (hclk),
    .hreset_n      (hreset_n),
    .hreq          (hreq),
    .hprior        (hp),
    .hlast         (hlast),
    .hready        (hready),
    .hgrant        (hgrant),
    .hmaster       (hmaster),
    .hmaster_valid (hmaster_valid),
    .arb_timeout   (arb_timeout)
  );
  task automatic tick(input int n = 1);
    repeat (n) @(posedge hclk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_grant(input string tag, input logic [7:0] g, input logic [2:0] m);
    chk({tag, " hgrant"}, 32'(hgrant), 32'(g));
    chk({tag, " hmaster"}, 32'(hmaster), 32'(m));
    chk({tag, " valid"}, 32'(hmaster_valid), 32'(|g));
  endtask
  initial begin
    hreset_n = 1'b0; hreq = '0; hlast = '0; hp = '0; hready = 1'b1;
    tick(2);
    chk_grant("reset", 8'h00, 3'd0);
    chk("reset timeout", 32'(arb_timeout), 32'd0);
    hreset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle", {30'd0, hmaster_valid, |hgrant}, 32'd0);
    end
    // priority: master 2 at level 3 beats master 0 at level 1
    hreq = 8'b0000_0101; hp[0] = 2'd1; hp[2] = 2'd3;
    #1;
    chk("prio pre-edge", 32'(hgrant), 32'h00);
    tick();
    chk_grant("prio", 8'h04, 3'd2);
    hreq = '0; hp = '0;
    tick();
    chk_grant("prio release", 8'h00, 3'd0);
    // burst lock: higher priority master 5 cannot preempt master 1
    hreq = 8'h02;
    tick();
    chk_grant("lock own", 8'h02, 3'd1);
    hreq = 8'h22; hp[5] = 2'd3;
    tick(2);
    chk_grant("lock hold", 8'h02, 3'd1);
    hlast = 8'h02;
    tick();
    chk_grant("lock handover", 8'h20, 3'd5);
    tick();
    chk_grant("lock nonowner hlast", 8'h20, 3'd5);
    hlast = '0;
    // asynchronous reset mid-burst
    #2 hreset_n = 1'b0;
    #1;
    chk_grant("async reset", 8'h00, 3'd0);
    tick();
    hreset_n = 1'b1; hreq = '0; hp = '0;
    tick();
    chk_grant("post reset idle", 8'h00, 3'd0);
    // round robin among 0,3,6 with single-beat bursts, rr_ptr restarts at 0
    hreq = 8'b0100_1001; hlast = 8'hFF; hp = '{default: 2'd2};
    tick(); chk_grant("rr 1", 8'h01, 3'd0);
    tick(); chk_grant("rr 2", 8'h08, 3'd3);
    tick(); chk_grant("rr 3", 8'h40, 3'd6);
    tick(); chk_grant("rr wrap", 8'h01, 3'd0);
    tick(); chk_grant("rr 5", 8'h08, 3'd3);
    hreq = '0; hlast = '0; hp = '0;
    tick();
    chk_grant("rr idle", 8'h00, 3'd0);
    // hready stall, then abort by dropping hreq
    hreq = 8'h10; hp[4] = 2'd1;
    tick();
    chk_grant("stall own", 8'h10, 3'd4);
    hreq = 8'h90; hp[7] = 2'd3; hlast = 8'h10; hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_grant("stall hold", 8'h10, 3'd4);
    end
    hready = 1'b1;
    tick();
    chk_grant("stall release", 8'h80, 3'd7);
    hlast = '0; hreq = 8'h10;
    tick();
    chk_grant("abort handover", 8'h10, 3'd4);
    hreq = '0; hp = '0;
    tick();
    chk_grant("abort idle", 8'h00, 3'd0);
    // hold limit: master 1 never ends its burst while master 2 waits
    hreq = 8'h06;
    tick();
    chk_grant("hold own", 8'h02, 3'd1);
    tick(3);
    chk_grant("hold 3 cycles", 8'h02, 3'd1);
    chk("hold no pulse", 32'(arb_timeout), 32'd0);
    tick();
`ifdef AHB_ARB_TIMEOUT_EN
    chk_grant("timeout handover", 8'h04, 3'd2);
    chk("timeout pulse", 32'(arb_timeout), 32'd1);
    tick();
    chk_grant("timeout after", 8'h04, 3'd2);
    chk("timeout single pulse", 32'(arb_timeout), 32'd0);
`else
    chk_grant("no timeout hold", 8'h02, 3'd1);
    chk("no timeout pulse", 32'(arb_timeout), 32'd0);
    tick(3);
    chk_grant("no timeout long hold", 8'h02, 3'd1);
`endif
    #2 hreset_n = 1'b0;
    #1;
    chk_grant("async reset 2", 8'h00, 3'd0);
    chk("async reset timeout", 32'(arb_timeout), 32'd0);
    hreq = '0;
    tick();
    hreset_n = 1'b1;
    tick(2);
    chk_grant("final idle", 8'h00, 3'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_slave_arbiter.md
Name: ahb_slave_arbiter

Overview:
Sequential arbiter sharing one AHB slave port among REQ_NUM masters. Picks the highest dynamic priority level among active requests, then round-robin within that level. Holds the grant for a whole burst until the owner signals its last beat with the slave ready. Sits between the master request/priority signals and the slave-side address/data mux select.

Parameters:
REQ_NUM, 8, number of requesting masters (2..16)
PRIOR_BIT, 2, width of each master's priority field
PRIOR_LEVEL, 4, number of priority levels (equals 2**PRIOR_BIT)
MAX_HOLD, 64, hold-cycle limit when AHB_ARB_TIMEOUT_EN is defined (>=2)

Ports:
hclk  in  1  clock, rising edge
hreset_n  in  1  asynchronous active-low reset
hreq  in  REQ_NUM  per-master bus request
hprior  in  REQ_NUM x PRIOR_BIT  per-master priority, higher value wins
hlast  in  REQ_NUM  per-master last-beat-of-burst flag
hready  in  1  slave ready; a beat completes when high
hgrant  out  REQ_NUM  one-hot grant, registered
hmaster  out  $clog2(REQ_NUM)  index of the owner, registered
hmaster_valid  out  1  high while any grant is held
arb_timeout  out  1  one-cycle pulse on forced release (macro only, else tied 0)

Behaviour:
- Reset (asynchronous, hreset_n low): state=IDLE, hgrant=0, hmaster=0, hmaster_valid=0, rr_ptr=0, hold_cnt=0, arb_timeout=0.
- States: IDLE and OWNED.
- Winner selection (combinational):
  - top = max hprior[i] over i with hreq[i]=1.
  - Candidates = requesters at level top.
  - Winner = first candidate at or after rr_ptr, wrapping modulo REQ_NUM.
- IDLE:
  - Any hreq -> next edge: hgrant=onehot(winner), hmaster=winner, hmaster_valid=1, state=OWNED.
  - Request-to-grant latency is 1 cycle.
  - No hreq -> remain IDLE with outputs 0.
- OWNED, owner o:
  - Grant holds while hreq[o]=1 and not (hlast[o] & hready).
  - hprior changes and higher-priority requests do not preempt.
- Release happens when (hlast[o] & hready) or hreq[o]=0. On release:
  - rr_ptr = (o+1) mod REQ_NUM.
  - Arbitration runs in the same cycle over the remaining requests, with hreq[o] masked for that cycle only.
  - A winner exists -> hand over directly at the next edge (OWNED->OWNED, no idle gap, hgrant one-hot throughout).
  - No winner -> IDLE with all outputs 0.
- hlast on a non-owner is ignored. hlast[o] with hready=0 is not a release; wait for hready.
- Invariant: hgrant is always one-hot or zero. hmaster_valid == |hgrant.
- hmaster is a combinational encode of the registered grant, or an equivalent register.
- Reset asserted mid-burst: grant drops immediately and asynchronously. Arbitration restarts from rr_ptr=0 after reset release.

Optional Feature:
AHB_ARB_TIMEOUT_EN
- Defined:
  - hold_cnt increments each OWNED cycle, saturating; cleared on every grant change.
  - When hold_cnt reaches MAX_HOLD-1 with no normal release, force release: same path as above with the owner masked.
  - arb_timeout pulses 1 cycle, registered, coincident with the new grant.
- Not defined: no counter, no forced release, arb_timeout tied 0. Bursts hold indefinitely.

Decomposition:
- Package ahb_arb_pkg holds:
  - typedef arb_state_e {IDLE, OWNED}
  - localparam function for index width
  - typedef for the REQ_NUM x PRIOR_BIT priority array
- One sub-module, ahb_rr_pick: combinational round-robin find-first over a REQ_NUM mask starting at rr_ptr. Outputs one-hot plus a found flag.
- Top level holds the priority-level masking, FSM, rr_ptr and hold counter.

Test Plan:
- Reset/idle: hreset_n low then high, hreq=0 -> hgrant=0, hmaster_valid=0 for 10 cycles.
- Priority: hreq=8'b0000_0101, hprior[0]=1, hprior[2]=3 -> grant 8'b0000_0100 one cycle later, hmaster=2.
- Burst lock: master 1 owns; master 5 raises hreq with prior 3 mid-burst -> grant stays 1. hlast[1]&hready -> next edge grant moves to 5 with no gap.
- Round-robin: masters 0,3,6 at equal prior, each sending single-beat hlast=1 bursts -> grant order 0,3,6,0 and rr_ptr wraps.
- hready stall/abort: owner hlast=1 with hready=0 for 3 cycles -> grant held. Owner drops hreq without hlast -> release next edge.
- Timeout (macro, MAX_HOLD=4): owner holds hreq with no hlast, master 2 requesting -> after 4 OWNED cycles grant moves to 2 and arb_timeout pulses once. Async reset mid-burst -> hgrant=0 immediately.
